hram_uart_cmd: RTL and testbench
================================

Name: hram_uart_cmd

Overview:
Serial command engine between the UART pair (uart_rx/uart_tx) and hyper_xface.
- Assembles 5-byte command frames from received bytes: 1 command byte, then 4 data bytes, MSB first.
- Drives the hyper_xface request interface: address, write data, read/write request pulses.
- Latches read data when hyper_xface returns it.
- Returns exactly 4 response bytes per frame through the uart_tx start/ready handshake.
- Replaces the ad-hoc serial logic in the top level. Adds inter-byte timeout resync and busy-aware request issue.

Parameters:
TIMEOUT_CYCLES, 12000, idle clocks allowed between bytes of one frame before the partial frame is discarded (1 ms at 12 MHz)
CONST_VAL, 32'd259, response word for the CONST command

Ports:
clk  in  1  system clock (hram_clk domain)
reset  in  1  asynchronous, active-high reset
rx_rcv  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
tx_start  out  1  one-cycle start strobe to uart_tx
tx_data  out  8  byte to transmit; stable from tx_start until uart_tx ready returns high
tx_ready  in  1  uart_tx idle
hr_busy  in  1  hyper_xface busy
hr_rd_req  out  1  one-cycle read request
hr_wr_req  out  1  one-cycle write request
hr_addr  out  32  address register
hr_wr_d  out  32  write data register
hr_rd_d  in  32  read data from hyper_xface
hr_rd_rdy  in  1  hr_rd_d valid strobe
frame_err  out  1  one-cycle pulse on timeout, dropped frame, or unknown command

Behaviour:
- Reset (async assert, sync release): all outputs 0; byte count 0; shift register 0; timeout counter 0; count 0; read-data latch 0; FSM IDLE.
- RX assembler:
  - Each rx_rcv shifts rx_data into a 40-bit register and increments byte_cnt (0..4).
  - When the byte with byte_cnt==4 arrives, the frame is complete and byte_cnt returns to 0.
  - Timeout counter clears on rx_rcv and counts only while byte_cnt!=0.
  - At TIMEOUT_CYCLES: byte_cnt<=0 and frame_err pulses. rx_rcv in the same cycle wins; no timeout fires.
- Frame completes while FSM is not IDLE: frame dropped, frame_err pulses, no response sent.
- Execution (FSM IDLE, frame complete; cmd = byte 0, D = bytes 1..4):
  - 0x01 ADDR: hr_addr<=D; resp=D.
  - 0x02 LOAD: hr_wr_d<=D; resp=D.
  - 0x03 WRITE: go to WAIT_BUSY; resp=0x00000003.
  - 0x04 READ: resp=read-data latch.
  - 0x05 READ_REQ: go to WAIT_BUSY; resp=0x00000005.
  - 0x06 COUNT: resp=count; count<=count+1 (wraps at 2^32).
  - 0x07 CONST: resp=CONST_VAL.
  - Other: resp=0xFFFFFFFF; frame_err pulses.
  - Non-WRITE/READ_REQ commands go directly to TX_LOAD.
- WAIT_BUSY: hold until hr_busy==0. The next cycle asserts hr_wr_req or hr_rd_req for exactly 1 cycle (REQ state), then TX_LOAD.
  - Earliest request: 2 cycles after frame completion.
- Read-data latch: hr_rd_rdy loads hr_rd_d in any state. A READ frame completing in the same cycle as hr_rd_rdy returns the old latch value.
- TX sequence, bytes resp[31:24] first, 4 bytes total:
  - TX_LOAD: wait tx_ready==1. Drive tx_data and pulse tx_start for 1 cycle.
  - TX_WAIT_LO: wait tx_ready==0. No cycle bound; uart_tx takes 1–2 cycles.
  - TX_WAIT_HI: wait tx_ready==1. Shift resp left 8; decrement bytes_left.
  - bytes_left reaching 0 → IDLE, else → TX_LOAD.
  - Never more than one tx_start per byte.
- Reset asserted mid-transaction aborts immediately: no partial request pulse, no further bytes.

Decomposition:
- Shared package/header (hram_cmd_pkg.vh): command codes CMD_ADDR..CMD_CONST, RESP_BAD=32'hFFFFFFFF, FSM state encodings.
- One sub-module, hram_frame_rx: byte shifter, byte counter, timeout counter. Outputs frame_valid, cmd, data, timeout_err.
- FSM and TX sequencer stay in hram_uart_cmd.

Test Plan:
- Frame 01 00 00 12 34 → hr_addr=0x00001234; TX bytes 00 00 12 34; exactly 4 tx_start pulses.
- Frames 01 00000010, 02 DEADBEEF, 03 00000000 with hr_busy high 20 cycles → hr_wr_req single pulse 1 cycle after busy drops; addr 0x10, wr_d 0xDEADBEEF; response 00 00 00 03.
- Frame 05 x4 → hr_rd_req pulse. Model returns hr_rd_rdy with 0xCAFEF00D; then frame 04 → TX CA FE F0 0D.
- Send 2 bytes, idle TIMEOUT_CYCLES → frame_err pulse. Then full frame 07 00000000 → TX 00 00 01 03.
- Frame 06 three times → responses 0, 1, 2. Frame 09 → FF FF FF FF plus frame_err.
- Second frame delivered during TX of the first → dropped, frame_err, only 4 bytes sent. Reset mid-TX → tx_start stays 0, outputs zero.

Source files
------------

// File: rtl/hram_uart_cmd_pkg.sv
// Shared command codes, response constants and FSM encoding for the serial command engine.
package hram_uart_cmd_pkg;

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned RESP_BYTES  = 4;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;

  localparam logic [31:0] RESP_BAD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_REQ,
    ST_TX_LOAD,
    ST_TX_WAIT_LO,
    ST_TX_WAIT_HI
  } state_t;

endpackage

// File: rtl/hram_uart_cmd_frame_rx.sv
// Assembles 5-byte command frames from UART bytes with inter-byte timeout resync.
module hram_frame_rx
  import hram_uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic [31:0] data,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [39:0]   shift_q;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] to_cnt;

  assign cmd  = shift_q[39:32];
  assign data = shift_q[31:0];

  // Byte shifter, byte counter and idle timeout; a received byte always beats a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_rcv) begin
        shift_q <= {shift_q[31:0], rx_data};
        to_cnt  <= '0;
        if (byte_cnt == 3'(FRAME_BYTES - 1)) begin
          byte_cnt    <= '0;
          frame_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 3'd1;
        end
      end else if (byte_cnt != 3'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          byte_cnt    <= '0;
          to_cnt      <= '0;
          timeout_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hram_uart_cmd.sv
// Serial command engine: decodes UART frames, drives hyper_xface requests, returns 4-byte responses.
module hram_uart_cmd
  import hram_uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12000,
  parameter logic [31:0] CONST_VAL      = 32'd259
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        hr_busy,
  output logic        hr_rd_req,
  output logic        hr_wr_req,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wr_d,
  input  logic [31:0] hr_rd_d,
  input  logic        hr_rd_rdy,
  output logic        frame_err
);

  logic        frame_valid;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic        timeout_err;

  hram_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_rcv      (rx_rcv),
    .rx_data     (rx_data),
    .frame_valid (frame_valid),
    .cmd         (cmd),
    .data        (data),
    .timeout_err (timeout_err)
  );

  state_t      state, state_nxt;
  logic [31:0] resp, resp_nxt;
  logic [2:0]  bytes_left, bytes_left_nxt;
  logic        is_rd, is_rd_nxt;
  logic [31:0] count, count_nxt;
  logic [31:0] rd_latch;
  logic [31:0] hr_addr_nxt, hr_wr_d_nxt;
  logic [7:0]  tx_data_nxt;
  logic        tx_start_nxt, hr_rd_req_nxt, hr_wr_req_nxt, frame_err_nxt;

  // State and output registers; reset aborts any request or transmission in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      resp       <= '0;
      bytes_left <= '0;
      is_rd      <= 1'b0;
      count      <= '0;
      rd_latch   <= '0;
      hr_addr    <= '0;
      hr_wr_d    <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      hr_rd_req  <= 1'b0;
      hr_wr_req  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp       <= resp_nxt;
      bytes_left <= bytes_left_nxt;
      is_rd      <= is_rd_nxt;
      count      <= count_nxt;
      if (hr_rd_rdy) rd_latch <= hr_rd_d;
      hr_addr    <= hr_addr_nxt;
      hr_wr_d    <= hr_wr_d_nxt;
      tx_data    <= tx_data_nxt;
      tx_start   <= tx_start_nxt;
      hr_rd_req  <= hr_rd_req_nxt;
      hr_wr_req  <= hr_wr_req_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Command execution, request issue and response byte sequencing.
  always_comb begin
    state_nxt      = state;
    resp_nxt       = resp;
    bytes_left_nxt = bytes_left;
    is_rd_nxt      = is_rd;
    count_nxt      = count;
    hr_addr_nxt    = hr_addr;
    hr_wr_d_nxt    = hr_wr_d;
    tx_data_nxt    = tx_data;
    tx_start_nxt   = 1'b0;
    hr_rd_req_nxt  = 1'b0;
    hr_wr_req_nxt  = 1'b0;
    frame_err_nxt  = timeout_err;

    case (state)
      ST_IDLE: begin
        if (frame_valid) begin
          bytes_left_nxt = 3'(RESP_BYTES);
          state_nxt      = ST_TX_LOAD;
          case (cmd)
            CMD_ADDR: begin
              hr_addr_nxt = data;
              resp_nxt    = data;
            end
            CMD_LOAD: begin
              hr_wr_d_nxt = data;
              resp_nxt    = data;
            end
            CMD_WRITE: begin
              is_rd_nxt = 1'b0;
              resp_nxt  = 32'h0000_0003;
              state_nxt = ST_WAIT_BUSY;
            end
            CMD_READ: resp_nxt = rd_latch;
            CMD_READ_REQ: begin
              is_rd_nxt = 1'b1;
              resp_nxt  = 32'h0000_0005;
              state_nxt = ST_WAIT_BUSY;
            end
            CMD_COUNT: begin
              resp_nxt  = count;
              count_nxt = count + 32'd1;
            end
            CMD_CONST: resp_nxt = CONST_VAL;
            default: begin
              resp_nxt      = RESP_BAD;
              frame_err_nxt = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_BUSY: begin
        if (!hr_busy) begin
          hr_rd_req_nxt = is_rd;
          hr_wr_req_nxt = !is_rd;
          state_nxt     = ST_REQ;
        end
      end
      ST_REQ: state_nxt = ST_TX_LOAD;
      ST_TX_LOAD: begin
        if (tx_ready) begin
          tx_data_nxt  = resp[31:24];
          tx_start_nxt = 1'b1;
          state_nxt    = ST_TX_WAIT_LO;
        end
      end
      ST_TX_WAIT_LO: begin
        if (!tx_ready) state_nxt = ST_TX_WAIT_HI;
      end
      ST_TX_WAIT_HI: begin
        if (tx_ready) begin
          resp_nxt       = {resp[23:0], 8'h00};
          bytes_left_nxt = bytes_left - 3'd1;
          state_nxt      = (bytes_left == 3'd1) ? ST_IDLE : ST_TX_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A frame arriving while busy with the previous one is discarded.
    if (frame_valid && (state != ST_IDLE)) frame_err_nxt = 1'b1;
  end

endmodule

// File: tb/tb_hram_uart_cmd.sv
// Directed self-checking bench for hram_uart_cmd with a simple uart_tx responder.
module tb_hram_uart_cmd;

  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_rcv = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        hr_busy = 1'b0;
  logic        hr_rd_req;
  logic        hr_wr_req;
  logic [31:0] hr_addr;
  logic [31:0] hr_wr_d;
  logic [31:0] hr_rd_d = '0;
  logic        hr_rd_rdy = 1'b0;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  hram_uart_cmd #(
    .TIMEOUT_CYCLES(T),
    .CONST_VAL     (32'd259)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_rcv    (rx_rcv),
    .rx_data   (rx_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .hr_busy   (hr_busy),
    .hr_rd_req (hr_rd_req),
    .hr_wr_req (hr_wr_req),
    .hr_addr   (hr_addr),
    .hr_wr_d   (hr_wr_d),
    .hr_rd_d   (hr_rd_d),
    .hr_rd_rdy (hr_rd_rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // uart_tx responder: captures each started byte, busy for a few cycles.
  logic [7:0] txq[$];
  int         n_start = 0;
  int         tx_cnt = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ready <= 1'b1;
      tx_cnt   <= 0;
    end else if (tx_start) begin
      txq.push_back(tx_data);
      n_start  <= n_start + 1;
      tx_ready <= 1'b0;
      tx_cnt   <= 3;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_ready <= 1'b1;
    end
  end

  // Pulse counters for requests and errors.
  int n_wr = 0, n_rd = 0, n_ferr = 0;
  always @(posedge clk) begin
    if (hr_wr_req) n_wr <= n_wr + 1;
    if (hr_rd_req) n_rd <= n_rd + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rcv  = 1'b1;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
    send_byte(c);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp);
    int k = 0;
    while (txq.size() < 4 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (15) @(negedge clk);
    chk({tag, " nbytes"}, 32'(txq.size()), 32'd4);
    if (txq.size() >= 4) chk({tag, " resp"}, {txq[0], txq[1], txq[2], txq[3]}, exp);
    txq.delete();
  endtask

  initial begin
    int ferr0, k, s0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset ctl", {20'd0, tx_start, hr_rd_req, hr_wr_req, frame_err, tx_data}, 32'd0);
    chk("reset addr", hr_addr, 32'd0);
    chk("reset wr_d", hr_wr_d, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ADDR command echoes data.
    ferr0 = n_ferr;
    send_frame(8'h01, 32'h0000_1234);
    wait_resp("addr", 32'h0000_1234);
    chk("addr reg", hr_addr, 32'h0000_1234);
    chk("addr nstart", 32'(n_start), 32'd4);
    chk("addr no err", 32'(n_ferr - ferr0), 32'd0);

    // WRITE with busy held, request issued one cycle after busy drops.
    send_frame(8'h01, 32'h0000_0010);
    wait_resp("addr2", 32'h0000_0010);
    send_frame(8'h02, 32'hDEAD_BEEF);
    wait_resp("load", 32'hDEAD_BEEF);
    hr_busy = 1'b1;
    send_frame(8'h03, 32'h0000_0000);
    repeat (20) @(negedge clk);
    chk("wr held", 32'(n_wr), 32'd0);
    chk("wr no tx", 32'(txq.size()), 32'd0);
    hr_busy = 1'b0;
    @(negedge clk);
    chk("wr_req on", {31'd0, hr_wr_req}, 32'd1);
    chk("wr addr", hr_addr, 32'h0000_0010);
    chk("wr data", hr_wr_d, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_req off", {31'd0, hr_wr_req}, 32'd0);
    wait_resp("write", 32'h0000_0003);
    chk("wr count", 32'(n_wr), 32'd1);
    chk("wr no rd", 32'(n_rd), 32'd0);

    // READ_REQ: earliest request two cycles after frame completion.
    send_frame(8'h05, 32'h0505_0505);
    @(negedge clk);
    chk("rd_req early", {31'd0, hr_rd_req}, 32'd0);
    @(negedge clk);
    chk("rd_req on", {31'd0, hr_rd_req}, 32'd1);
    wait_resp("read_req", 32'h0000_0005);
    chk("rd count", 32'(n_rd), 32'd1);
    hr_rd_d   = 32'hCAFE_F00D;
    hr_rd_rdy = 1'b1;
    @(negedge clk);
    hr_rd_rdy = 1'b0;
    send_frame(8'h04, 32'h0000_0000);
    wait_resp("read", 32'hCAFE_F00D);

    // READ completing with hr_rd_rdy in the same cycle returns the old latch.
    send_frame(8'h04, 32'h0000_0000);
    hr_rd_d   = 32'h1111_2222;
    hr_rd_rdy = 1'b1;
    @(negedge clk);
    hr_rd_rdy = 1'b0;
    wait_resp("read same", 32'hCAFE_F00D);
    send_frame(8'h04, 32'h0000_0000);
    wait_resp("read new", 32'h1111_2222);

    // Partial frame times out, then a full CONST frame resyncs.
    ferr0 = n_ferr;
    send_byte(8'h07);
    send_byte(8'h00);
    k = 0;
    while (!frame_err && k < int'(T) + 20) begin
      @(negedge clk);
      k++;
    end
    chk("timeout seen", {31'd0, frame_err}, 32'd1);
    chk("timeout window", 32'((k >= int'(T) && k <= int'(T) + 2) ? 1 : 0), 32'd1);
    repeat (3) @(negedge clk);
    chk("timeout once", 32'(n_ferr - ferr0), 32'd1);
    chk("timeout no tx", 32'(txq.size()), 32'd0);
    send_frame(8'h07, 32'h0000_0000);
    wait_resp("const", 32'h0000_0103);

    // COUNT increments per use; unknown command flags an error.
    send_frame(8'h06, 32'h0);
    wait_resp("count0", 32'd0);
    send_frame(8'h06, 32'h0);
    wait_resp("count1", 32'd1);
    send_frame(8'h06, 32'h0);
    wait_resp("count2", 32'd2);
    ferr0 = n_ferr;
    send_frame(8'h09, 32'h1234_5678);
    wait_resp("bad", 32'hFFFF_FFFF);
    chk("bad err", 32'(n_ferr - ferr0), 32'd1);

    // Frame arriving during TX is dropped.
    ferr0 = n_ferr;
    send_frame(8'h07, 32'h0);
    k = 0;
    while (txq.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    send_frame(8'h01, 32'hAABB_CCDD);
    wait_resp("overlap", 32'h0000_0103);
    chk("overlap err", 32'(n_ferr - ferr0), 32'd1);
    chk("overlap addr", hr_addr, 32'h0000_0010);

    // Reset mid-TX aborts the response.
    send_frame(8'h07, 32'h0);
    k = 0;
    while (txq.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    #1;
    s0 = n_start;
    chk("rst ctl", {20'd0, tx_start, hr_rd_req, hr_wr_req, frame_err, tx_data}, 32'd0);
    chk("rst addr", {hr_addr | hr_wr_d}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst no start", 32'(n_start - s0), 32'd0);
    chk("rst tx_start", {31'd0, tx_start}, 32'd0);
    txq.delete();
    send_frame(8'h06, 32'h0);
    wait_resp("count after rst", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
